// File: rtl/avdec_pkg.sv
// Shared types and constants for the Avalon-MM address decoder.
// Target and FSM encodings, response codes, DECODEERROR read data pattern.
`timescale 1ns/1ps
package avdec_pkg;

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } state_e;

  localparam logic [1:0]  RSP_OKAY   = 2'b00;
  localparam logic [1:0]  RSP_SLVERR = 2'b10;
  localparam logic [1:0]  RSP_DECERR = 2'b11;
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/avdec_err_slave.sv
// DECODEERROR responder for unmapped accesses; read beats start one cycle after accept,
// write response one cycle after the last beat; busy stalls new commands until drained.
`timescale 1ns/1ps
module avdec_err_slave
  import avdec_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rd_acc,
  input  logic        wr_last_acc,
  input  logic [4:0]  burstcount,
  output logic        busy,
  output logic        readdatavalid,
  output logic        writeresponsevalid,
  output logic [31:0] readdata,
  output logic [1:0]  response
);

  logic [4:0] rd_cnt;
  logic       wrsp;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
      wrsp   <= 1'b0;
    end else begin
      if (rd_acc) rd_cnt <= burstcount;
      else if (rd_cnt != '0) rd_cnt <= rd_cnt - 5'd1;
      wrsp <= wr_last_acc;
    end
  end

  assign busy               = (rd_cnt != '0) | wrsp;
  assign readdatavalid      = (rd_cnt != '0);
  assign writeresponsevalid = wrsp;
  assign readdata           = ERR_RDATA;
  assign response           = RSP_DECERR;

endmodule

// File: rtl/avalon_addr_decoder.sv
// One-master/two-slave Avalon-MM decoder, zero-latency command and response paths; stalls on
// target change with responses outstanding, pend overflow, or reads during a write burst. AVDEC_ERR_SLAVE_EN adds a DECODEERROR responder.
`timescale 1ns/1ps
module avalon_addr_decoder
  import avdec_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S0_SIZE  = 32'h0000_4000,
  parameter logic [31:0] S1_BASE  = 32'hFFFE_0000,
  parameter logic [31:0] S1_SIZE  = 32'h0000_4000,
  parameter int          MAX_PEND = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m_address,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [4:0]  m_burstcount,
  input  logic [31:0] m_writedata,
  input  logic [3:0]  m_byteenable,
  output logic        m_waitrequest,
  output logic [31:0] m_readdata,
  output logic        m_readdatavalid,
  output logic        m_writeresponsevalid,
  output logic [1:0]  m_response,
  output logic [29:0] s0_address,
  output logic        s0_read,
  output logic        s0_write,
  output logic [4:0]  s0_burstcount,
  output logic [31:0] s0_writedata,
  output logic [3:0]  s0_byteenable,
  input  logic        s0_waitrequest,
  input  logic        s0_readdatavalid,
  input  logic        s0_writeresponsevalid,
  input  logic [31:0] s0_readdata,
  input  logic [1:0]  s0_response,
  output logic [29:0] s1_address,
  output logic        s1_read,
  output logic        s1_write,
  output logic [4:0]  s1_burstcount,
  output logic [31:0] s1_writedata,
  output logic [3:0]  s1_byteenable,
  input  logic        s1_waitrequest,
  input  logic        s1_readdatavalid,
  input  logic        s1_writeresponsevalid,
  input  logic [31:0] s1_readdata,
  input  logic [1:0]  s1_response
);

  localparam int PW = $clog2(MAX_PEND) + 1;

  state_e        state;
  tgt_e          rsp_tgt, wtgt, dec_tgt, cmd_tgt;
  logic [4:0]    wbeats;
  logic [PW-1:0] pend, pend_add, pend_dec, pend_nxt;
  logic [7:0]    stray_cnt;

  logic        hit0, hit1, m_cmd, stall, fwd, accept, wr_last, tgt_wait;
  logic [31:0] cost, pend_sum;
  logic        err_busy, err_rdv, err_wrv;
  logic [31:0] err_rdata;
  logic [1:0]  err_resp;
  logic        rdv_mux, wrv_mux;
  logic [31:0] rdata_mux;
  logic [1:0]  resp_mux;
  logic        stray0, stray1;
  logic [1:0]  stray_inc;
  logic [8:0]  stray_sum;

  assign hit0 = (m_address & ~(S0_SIZE - 32'd1)) == S0_BASE;
  assign hit1 = (m_address & ~(S1_SIZE - 32'd1)) == S1_BASE;

`ifdef AVDEC_ERR_SLAVE_EN
  assign dec_tgt = hit0 ? TGT_S0 : (hit1 ? TGT_S1 : TGT_ERR);
`else
  assign dec_tgt = (hit0 || !hit1) ? TGT_S0 : TGT_S1;
`endif

  // Later beats of a write burst follow the first beat, whatever their address.
  assign cmd_tgt  = (state == WBURST) ? wtgt : dec_tgt;
  assign m_cmd    = m_read | m_write;
  assign cost     = m_read ? {27'd0, m_burstcount} : 32'd1;
  assign pend_sum = 32'(pend) + cost;
  assign stall    = ((cmd_tgt != rsp_tgt) && (pend != '0)) ||
                    (pend_sum > 32'(MAX_PEND)) ||
                    ((state == WBURST) && m_read);

  always_comb begin
    tgt_wait = 1'b0;
    case (cmd_tgt)
      TGT_S0:  tgt_wait = s0_waitrequest;
      TGT_S1:  tgt_wait = s1_waitrequest;
      default: tgt_wait = err_busy;
    endcase
  end

  assign fwd           = rst_ni & m_cmd & ~stall;
  assign m_waitrequest = ~rst_ni | stall | tgt_wait;
  assign accept        = m_cmd & ~m_waitrequest;
  assign wr_last       = m_write & ((state == IDLE) ? (m_burstcount <= 5'd1) : (wbeats == 5'd1));

  assign s0_read       = fwd & m_read  & (cmd_tgt == TGT_S0);
  assign s0_write      = fwd & m_write & (cmd_tgt == TGT_S0);
  assign s1_read       = fwd & m_read  & (cmd_tgt == TGT_S1);
  assign s1_write      = fwd & m_write & (cmd_tgt == TGT_S1);
  assign s0_address    = m_address[31:2];
  assign s1_address    = m_address[31:2];
  assign s0_burstcount = m_burstcount;
  assign s1_burstcount = m_burstcount;
  assign s0_writedata  = m_writedata;
  assign s1_writedata  = m_writedata;
  assign s0_byteenable = m_byteenable;
  assign s1_byteenable = m_byteenable;

`ifdef AVDEC_ERR_SLAVE_EN
  avdec_err_slave u_err (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .rd_acc             (accept & m_read & (cmd_tgt == TGT_ERR)),
    .wr_last_acc        (accept & wr_last & (cmd_tgt == TGT_ERR)),
    .burstcount         (m_burstcount),
    .busy               (err_busy),
    .readdatavalid      (err_rdv),
    .writeresponsevalid (err_wrv),
    .readdata           (err_rdata),
    .response           (err_resp)
  );
`else
  assign err_busy  = 1'b0;
  assign err_rdv   = 1'b0;
  assign err_wrv   = 1'b0;
  assign err_rdata = ERR_RDATA;
  assign err_resp  = RSP_DECERR;
`endif

  always_comb begin
    rdv_mux   = 1'b0;
    wrv_mux   = 1'b0;
    rdata_mux = '0;
    resp_mux  = RSP_OKAY;
    case (rsp_tgt)
      TGT_S0: begin
        rdv_mux = s0_readdatavalid; wrv_mux = s0_writeresponsevalid;
        rdata_mux = s0_readdata; resp_mux = s0_response;
      end
      TGT_S1: begin
        rdv_mux = s1_readdatavalid; wrv_mux = s1_writeresponsevalid;
        rdata_mux = s1_readdata; resp_mux = s1_response;
      end
      default: begin
        rdv_mux = err_rdv; wrv_mux = err_wrv;
        rdata_mux = err_rdata; resp_mux = err_resp;
      end
    endcase
  end

  assign m_readdatavalid      = rst_ni & rdv_mux;
  assign m_writeresponsevalid = rst_ni & wrv_mux;
  assign m_readdata           = rdata_mux;
  assign m_response           = rst_ni ? resp_mux : RSP_OKAY;

  assign stray0    = (s0_readdatavalid | s0_writeresponsevalid) & (rsp_tgt != TGT_S0);
  assign stray1    = (s1_readdatavalid | s1_writeresponsevalid) & (rsp_tgt != TGT_S1);
  assign stray_inc = {1'b0, stray0} + {1'b0, stray1};
  assign stray_sum = {1'b0, stray_cnt} + {7'd0, stray_inc};

  always_comb begin
    pend_add = '0;
    if (accept && m_read)       pend_add = PW'(m_burstcount);
    else if (accept && wr_last) pend_add = PW'(1);
  end

  assign pend_dec = {{(PW-1){1'b0}}, m_readdatavalid} + {{(PW-1){1'b0}}, m_writeresponsevalid};
  assign pend_nxt = pend + pend_add - pend_dec;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rsp_tgt   <= TGT_S0;
      wtgt      <= TGT_S0;
      wbeats    <= '0;
      pend      <= '0;
      stray_cnt <= '0;
    end else begin
      pend      <= pend_nxt;
      stray_cnt <= stray_sum[8] ? 8'hFF : stray_sum[7:0];
      if (accept && ((pend == '0) || (pend_nxt == '0))) rsp_tgt <= cmd_tgt;
      case (state)
        IDLE: begin
          if (accept && m_write) begin
            wtgt   <= cmd_tgt;
            wbeats <= (m_burstcount > 5'd1) ? (m_burstcount - 5'd1) : 5'd0;
            if (m_burstcount > 5'd1) state <= WBURST;
          end
        end
        WBURST: begin
          if (accept && m_write) begin
            wbeats <= wbeats - 5'd1;
            if (wbeats == 5'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_addr_decoder.sv
// Directed bench: reactive slave models plus an in-order response scoreboard.
`timescale 1ns/1ps
module tb_avalon_addr_decoder;
  import avdec_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] m_address = '0;
  logic        m_read = 1'b0, m_write = 1'b0;
  logic [4:0]  m_burstcount = 5'd1;
  logic [31:0] m_writedata = '0;
  logic [3:0]  m_byteenable = 4'hF;
  logic        m_waitrequest, m_readdatavalid, m_writeresponsevalid;
  logic [31:0] m_readdata;
  logic [1:0]  m_response;
  logic [29:0] s0_address, s1_address;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [4:0]  s0_burstcount, s1_burstcount;
  logic [31:0] s0_writedata, s1_writedata;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_waitrequest = 1'b0, s1_waitrequest = 1'b0;
  logic        s0_readdatavalid, s0_writeresponsevalid, s1_readdatavalid, s1_writeresponsevalid;
  logic [31:0] s0_readdata, s1_readdata;
  logic [1:0]  s0_response = RSP_OKAY, s1_response = RSP_OKAY;
  logic        hold0 = 1'b0, hold1 = 1'b0;

  int checks = 0;
  int errors = 0;
  int rd_beats = 0;

  always #5 clk_i = ~clk_i;

  avalon_addr_decoder #(.MAX_PEND(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_writeresponsevalid(m_writeresponsevalid), .m_response(m_response),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write), .s0_burstcount(s0_burstcount),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_waitrequest(s0_waitrequest),
    .s0_readdatavalid(s0_readdatavalid), .s0_writeresponsevalid(s0_writeresponsevalid),
    .s0_readdata(s0_readdata), .s0_response(s0_response),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write), .s1_burstcount(s1_burstcount),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_waitrequest(s1_waitrequest),
    .s1_readdatavalid(s1_readdatavalid), .s1_writeresponsevalid(s1_writeresponsevalid),
    .s1_readdata(s1_readdata), .s1_response(s1_response)
  );

  function automatic logic [31:0] sdat(input int g, input logic [31:0] a);
    return (g == 0) ? (a ^ 32'h1234_5668) : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Slave models: one-cycle response latency, hold flag freezes the response queue.
  typedef struct packed { logic wr; logic [31:0] d; } sbeat_t;

  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic        rd_s, wr_s, h;
    logic [29:0] a_s;
    logic [4:0]  bc_s;
    logic        rdv = 1'b0, wrv = 1'b0;
    logic [31:0] dat = '0;
    sbeat_t      q[$];
    int          wcnt = 0;
    assign rd_s = (g == 0) ? s0_read : s1_read;
    assign wr_s = (g == 0) ? s0_write : s1_write;
    assign a_s  = (g == 0) ? s0_address : s1_address;
    assign bc_s = (g == 0) ? s0_burstcount : s1_burstcount;
    assign h    = (g == 0) ? hold0 : hold1;
    always @(posedge clk_i) begin
      sbeat_t e;
      rdv <= 1'b0;
      wrv <= 1'b0;
      if (!h && q.size() > 0) begin
        e = q.pop_front();
        rdv <= !e.wr;
        wrv <= e.wr;
        dat <= e.d;
      end
      if (rd_s)
        for (int i = 0; i < int'(bc_s); i++) q.push_back({1'b0, sdat(g, {a_s, 2'b00} + 32'(4 * i))});
      if (wr_s) begin
        if (wcnt == 0) wcnt = int'(bc_s);
        wcnt--;
        if (wcnt == 0) q.push_back({1'b1, 32'h0});
      end
    end
  end

  assign s0_readdatavalid      = g_slv[0].rdv;
  assign s0_writeresponsevalid = g_slv[0].wrv;
  assign s0_readdata           = g_slv[0].dat;
  assign s1_readdatavalid      = g_slv[1].rdv;
  assign s1_writeresponsevalid = g_slv[1].wrv;
  assign s1_readdata           = g_slv[1].dat;

  typedef struct packed { logic wr; logic [31:0] d; logic [1:0] r; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni === 1'b1 && (m_readdatavalid || m_writeresponsevalid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {m_readdatavalid, m_writeresponsevalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        if (e.wr) begin
          check("wr_rsp", {m_writeresponsevalid, m_readdatavalid, m_response}, {1'b1, 1'b0, e.r});
        end else begin
          check("rd_rsp", {m_readdatavalid, m_writeresponsevalid, m_readdata, m_response},
                {1'b1, 1'b0, e.d, e.r});
          rd_beats++;
        end
      end
    end
  end

  task automatic exp_rd(input int g, input logic [31:0] a, input int bc);
    for (int i = 0; i < bc; i++) exp_q.push_back({1'b0, sdat(g, a + 32'(4 * i)), RSP_OKAY});
  endtask

  // Holds the command until accepted; returns the slave strobes seen in the accept cycle.
  task automatic issue(input logic rd, input logic [31:0] a, input logic [4:0] bc,
                       output logic [3:0] strb);
    logic w;
    m_read = rd; m_write = !rd; m_address = a; m_burstcount = bc;
    m_writedata = a ^ 32'hFACE_0000; m_byteenable = 4'hF;
    strb = '0;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk_i);
      w = m_waitrequest;
      strb = {s0_read, s1_read, s0_write, s1_write};
      @(posedge clk_i); #1;
      if (!w) break;
      if (n == 200) check("accept_timeout", 64'(n), 64'd0);
    end
    m_read = 1'b0; m_write = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (dut.pend == '0 && exp_q.size() == 0) break;
    end
    check(tag, {32'(dut.pend), 32'(exp_q.size())}, 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [3:0] strb;
    int b0;
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] strb;
    int b0;
    m_read = 1'b1; m_address = 32'h10;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_outputs", {m_waitrequest, s0_read, s1_read, s0_write, s1_write,
                          m_readdatavalid, m_writeresponsevalid, m_response}, 9'b1_0000_00_00);
    @(posedge clk_i); #1;
    m_read = 1'b0; rst_ni = 1'b1;
    check("rst_state", {dut.pend, dut.stray_cnt, dut.rsp_tgt, dut.state, dut.wbeats}, 64'd0);

    // single read to slave 0
    exp_rd(0, 32'h10, 1);
    issue(1'b1, 32'h10, 5'd1, strb);
    check("t1_strobe", strb, 4'b1000);
    check("t1_data_model", sdat(0, 32'h10), 32'h1234_5678);
    drain("t1_drain");

    // s1 burst then s0 read: s0 held until all four s1 beats are routed
    exp_rd(1, 32'hFFFE_0000, 4);
    issue(1'b1, 32'hFFFE_0000, 5'd4, strb);
    check("t2_s1_strobe", strb, 4'b0100);
    b0 = rd_beats;
    exp_rd(0, 32'h0, 1);
    issue(1'b1, 32'h0, 5'd1, strb);
    check("t2_s0_strobe", strb, 4'b1000);
    check("t2_beats_before_s0", 64'(rd_beats - b0), 64'd4);
    drain("t2_drain");

    // write burst crossing the end of window 0 stays on slave 0
    exp_q.push_back({1'b1, 32'h0, RSP_OKAY});
    issue(1'b0, 32'h0000_3FFC, 5'd3, strb);
    check("t3_beat0", strb, 4'b0010);
    issue(1'b0, 32'h0000_4000, 5'd3, strb);
    check("t3_beat1", strb, 4'b0010);
    issue(1'b0, 32'h0000_4004, 5'd3, strb);
    check("t3_beat2", strb, 4'b0010);
    check("t3_state_idle", dut.state, IDLE);
    drain("t3_drain");

    // second beat addresses window 1 but is locked to slave 0
    exp_q.push_back({1'b1, 32'h0, RSP_OKAY});
    issue(1'b0, 32'h0000_0100, 5'd2, strb);
    check("t3b_beat0", strb, 4'b0010);
    issue(1'b0, 32'hFFFE_0100, 5'd2, strb);
    check("t3b_beat1_locked", strb, 4'b0010);
    drain("t3b_drain");

    // unmapped read
`ifdef AVDEC_ERR_SLAVE_EN
    exp_q.push_back({1'b0, 32'hDEAD_BEEF, 2'b11});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF, 2'b11});
    issue(1'b1, 32'h8000_0000, 5'd2, strb);
    check("t4_no_strobe", strb, 4'b0000);
`else
    exp_rd(0, 32'h8000_0000, 2);
    issue(1'b1, 32'h8000_0000, 5'd2, strb);
    check("t4_default_s0", strb, 4'b1000);
`endif
    drain("t4_drain");

    // pend capacity: third 16-beat read waits until pend drops to 16
    hold0 = 1'b1;
    exp_rd(0, 32'h0, 16);
    issue(1'b1, 32'h0, 5'd16, strb);
    exp_rd(0, 32'h40, 16);
    issue(1'b1, 32'h40, 5'd16, strb);
    check("t5_pend_full", 64'(dut.pend), 64'd32);
    exp_rd(0, 32'h80, 16);
    m_read = 1'b1; m_address = 32'h80; m_burstcount = 5'd16;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("t5_cap_stall", {m_waitrequest, s0_read}, 2'b10);
    @(posedge clk_i); #1;
    hold0 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (!m_waitrequest) break;
    end
    check("t5_release_pend", 64'(dut.pend), 64'd16);
    check("t5_release_strobe", s0_read, 1'b1);
    @(posedge clk_i); #1;
    m_read = 1'b0;
    drain("t5_drain");

    // reset during the second beat of a 4-beat s1 read
    hold1 = 1'b1;
    exp_rd(1, 32'hFFFE_0000, 4);
    issue(1'b1, 32'hFFFE_0000, 5'd4, strb);
    check("t6_strobe", strb, 4'b0100);
    hold1 = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    exp_q.delete();
    b0 = rd_beats;
    @(negedge clk_i);
    check("t6_rst_outputs", {m_readdatavalid, m_waitrequest, m_writeresponsevalid, m_response}, 5'b01000);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("t6_rst_state", {dut.pend, dut.rsp_tgt, dut.state, dut.wbeats, dut.stray_cnt}, 64'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("t6_stray_cnt", 64'(dut.stray_cnt), 64'd2);
    check("t6_no_late_beats", 64'(rd_beats - b0), 64'd0);
    check("t6_pend", 64'(dut.pend), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_addr_decoder.md
# avalon_addr_decoder

Single-master, two-slave Avalon-MM address decoder and response router that replaces the OR-wired bus fabric between `CoreWrapper` and its memory slaves. It decodes each command against two address windows, forwards the command only to the selected slave, and routes `readdata`/`writeresponsevalid` back in order by tracking outstanding response beats. Optionally, it answers unmapped accesses with an internal DECODEERROR responder.

## Interface
- `S0_BASE`, default 32'h0000_0000: byte base address of slave 0 (main memory).
- `S0_SIZE`, default 32'h0000_4000: byte size of window 0; power of two; base aligned to size.
- `S1_BASE`, default 32'hFFFE_0000: byte base address of slave 1 (ROM).
- `S1_SIZE`, default 32'h0000_4000: byte size of window 1; same rules as window 0.
- `MAX_PEND`, default 32: maximum outstanding response beats (read beats plus write responses).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `m_address` in 32: byte address from master.
- `m_read`, `m_write` in 1 each: command strobes.
- `m_burstcount` in 5: burst length, 1..16.
- `m_writedata` in 32, `m_byteenable` in 4: write payload.
- `m_waitrequest` out 1: stall to master.
- `m_readdata` out 32, `m_readdatavalid` out 1: read response to master.
- `m_writeresponsevalid` out 1, `m_response` out 2: write/read status (00 OKAY, 10 SLVERR, 11 DECODEERROR).
- `sN_address` out 30 (word address), `sN_read`, `sN_write` out 1, `sN_burstcount` out 5, `sN_writedata` out 32, `sN_byteenable` out 4, for N = 0, 1: command to each slave.
- `sN_waitrequest`, `sN_readdatavalid`, `sN_writeresponsevalid` in 1, `sN_readdata` in 32, `sN_response` in 2, for N = 0, 1: responses from each slave.

## Operation
- Decode is combinational: `hit0` when `(m_address & ~(S0_SIZE-1)) == S0_BASE`, else `hit1` likewise, else miss. Window 0 wins on overlap.
- Command forwarding: `sN_read`/`sN_write` assert only for the selected target. Address, data, burstcount and byteenable fan out unchanged to both slaves; `sN_address = m_address[31:2]`.
- Response routing: a register `rsp_tgt` (0, 1, ERR) holds the target owning the outstanding responses. `m_readdata`, `m_readdatavalid`, `m_writeresponsevalid` and `m_response` are muxed from `rsp_tgt`. Responses from a non-owning slave are ignored and counted in `stray_cnt`, an internal 8-bit saturating counter.
- `pend` counter, width $clog2(MAX_PEND)+1:
  - Accepted read adds `m_burstcount`.
  - Accepted final write-burst beat adds 1.
  - Each routed `readdatavalid` or `writeresponsevalid` subtracts 1.
  - Add and subtract in the same cycle net out.
- Ordering stall: a new command is held (`m_waitrequest=1`, not forwarded) when any of the following holds:
  - its target differs from `rsp_tgt` and `pend != 0`;
  - `pend + cost > MAX_PEND`, where cost is burstcount for a read and 1 for a write.
- Write-burst lock: the first accepted write beat latches the target and loads `wbeats = m_burstcount-1`. Later beats go to the latched target regardless of address; decoding resumes at `wbeats==0`.
- FSM `IDLE`→`WBURST` (accepted first beat with burstcount>1), `WBURST`→`IDLE` (last beat accepted). Reads never enter `WBURST`. Read commands arriving in `WBURST` are stalled.
- Otherwise `m_waitrequest` = selected slave's `sN_waitrequest`.

## Timing
- Command path: zero latency, combinational from master to slave.
- Response path: zero added latency, combinational mux on registered `rsp_tgt`.
- Reset values: `pend=0`, `rsp_tgt=0`, state `IDLE`, `wbeats=0`, `stray_cnt=0`, error responder idle.
- While `rst_ni=0`: all `sN_read`/`sN_write`=0, `m_waitrequest=1`, `m_readdatavalid=0`, `m_writeresponsevalid=0`, `m_response=00`.
- `rsp_tgt` updates on the clock edge of an accepted command when `pend==0`, or when `pend` becomes 0 in the same cycle.
- Reset mid-burst drops all pending state. Responses still arriving from slaves after reset are counted as stray.

## Configuration
- `AVDEC_ERR_SLAVE_EN` defined:
  - Misses target an internal responder. Commands are accepted immediately (`m_waitrequest=0`).
  - A read returns `m_burstcount` beats of `readdata=32'hDEAD_BEEF`, `response=11`, one per cycle, starting the cycle after acceptance.
  - A write accepts all beats, then returns one `writeresponsevalid` with `response=11` the cycle after the last beat.
- `AVDEC_ERR_SLAVE_EN` not defined: misses route to slave 0 (default route). No DECODEERROR is generated.

## Structure
- Package `avdec_pkg`: `tgt_e` enum {TGT_S0, TGT_S1, TGT_ERR}, `state_e` {IDLE, WBURST}, `RSP_OKAY`/`RSP_SLVERR`/`RSP_DECERR` constants, `ERR_RDATA`.
- Sub-module `avdec_err_slave` holds the error responder (beat counter, pending write response). It is instantiated only under `AVDEC_ERR_SLAVE_EN`.

## Test plan
- Single read at 0x0000_0010 with slave 0 returning 0x1234_5678 -> `s0_read` pulses, `s1_read=0`, `m_readdata=0x1234_5678`, `pend` returns to 0.
- Read burst of 4 to 0xFFFE_0000 followed immediately by a read to 0x0 -> second command stalled until the 4th s1 beat, then forwarded to s0. Data order is preserved.
- Write burst of 3 starting 0x0000_3FFC (last word of window 0) -> all 3 beats on `s0_write` despite address crossing, one write response routed back.
- Read burst of 2 at 0x8000_0000 with `AVDEC_ERR_SLAVE_EN` -> 2 beats of 0xDEAD_BEEF, `response=11`, no slave strobe. Without the macro -> forwarded to s0.
- 16-beat reads issued back-to-back with `MAX_PEND=32` -> third read stalled until `pend <= 16`.
- `rst_ni` low during the 2nd beat of a 4-beat read -> outputs at reset values the next cycle. Late s1 beats increment `stray_cnt` and are not presented to the master.
